// File: rtl/mbu_ctx_sequencer_pkg.sv
// Shared definitions for the MBU context sequencer: MBU unit addresses
// and the sequencer state encoding.
package mbu_ctx_sequencer_pkg;

  localparam logic [4:0] ADDR_CTX = 5'b11110;
  localparam logic [4:0] ADDR_MBN = 5'b11011;
  localparam logic [4:0] ADDR_NOP = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CTX_SETUP,
    ST_CTX_STROBE,
    ST_XF_SETUP,
    ST_XF_STROBE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mbu_shadow_buf.sv
// 8x8 shadow register file: one synchronous write port, a host-facing
// combinational read port and an internal combinational read port.
module mbu_shadow_buf (
  input  logic       clk2,
  input  logic       we,
  input  logic [2:0] widx,
  input  logic [7:0] wdata,
  input  logic [2:0] ridx,
  output logic [7:0] rdata,
  input  logic [2:0] iidx,
  output logic [7:0] idata
);

  logic [7:0] mem [8];

  // Single write port; contents survive reset by design.
  always_ff @(posedge clk2) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];
  assign idata = mem[iidx];

endmodule

// File: rtl/mbu_ctx_sequencer.sv
// Bus initiator that saves or restores a full MBU bank context (CTX plus
// MB0-MB7) through the RADDR/WADDR/IBUS/IR lines, using a shadow buffer.
module mbu_ctx_sequencer
  import mbu_ctx_sequencer_pkg::*;
#(
  parameter int delay     = 15,
  parameter bit CTX_FIRST = 1'b1
) (
  input  logic       clk2,
  input  logic       nrsthold,
  input  logic       start,
  input  logic       save,
  input  logic [7:0] ctx_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic [4:0] raddr,
  output logic [4:0] waddr,
  output logic [2:0] ir_idx,
  output logic       ibus_oe,
  output logic [7:0] ibus_out,
  input  logic [7:0] ibus_in,
  input  logic       buf_we,
  input  logic [2:0] buf_widx,
  input  logic [7:0] buf_wdata,
  input  logic [2:0] buf_ridx,
  output logic [7:0] buf_rdata
);

  // Output propagation delay is a board-timing attribute; it has no
  // synthesizable effect and is kept only for interface compatibility.
  if (delay < 0) begin : g_delay_negative
  end

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic       save_q, save_n;
  logic [7:0] ctx_q, ctx_n;

  logic       busy_n, done_n, err_n, req_n, oe_n;
  logic [4:0] raddr_n, waddr_n;
  logic [2:0] ir_n;
  logic [7:0] out_n;

  logic       host_we, cap_we, mem_we;
  logic [2:0] mem_widx;
  logic [7:0] mem_wdata, buf_idata;

  // Host writes only while idle; save capture owns the port in XF_STROBE.
  assign host_we   = buf_we && (state == ST_IDLE);
  assign cap_we    = save_q && (state == ST_XF_STROBE);
  assign mem_we    = host_we || cap_we;
  assign mem_widx  = cap_we ? idx : buf_widx;
  assign mem_wdata = cap_we ? ibus_in : buf_wdata;

  mbu_shadow_buf u_buf (
    .clk2  (clk2),
    .we    (mem_we),
    .widx  (mem_widx),
    .wdata (mem_wdata),
    .ridx  (buf_ridx),
    .rdata (buf_rdata),
    .iidx  (idx_n),
    .idata (buf_idata)
  );

  // Next-state, index and operand latching; grant loss aborts to IDLE.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    save_n  = save_q;
    ctx_n   = ctx_q;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          save_n  = save;
          ctx_n   = ctx_in;
          state_n = ST_REQ;
        end
      end
      ST_REQ:        if (bus_gnt) state_n = CTX_FIRST ? ST_CTX_SETUP : ST_XF_SETUP;
      ST_CTX_SETUP:  state_n = ST_CTX_STROBE;
      ST_CTX_STROBE: state_n = ST_XF_SETUP;
      ST_XF_SETUP:   state_n = ST_XF_STROBE;
      ST_XF_STROBE: begin
        if (idx == 3'd7) begin
          idx_n   = '0;
          state_n = ST_DONE;
        end else begin
          idx_n   = idx + 3'd1;
          state_n = ST_XF_SETUP;
        end
      end
      ST_DONE: begin
        idx_n   = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (!bus_gnt && (state inside {ST_CTX_SETUP, ST_CTX_STROBE, ST_XF_SETUP, ST_XF_STROBE})) begin
      idx_n   = '0;
      state_n = ST_IDLE;
      err_n   = 1'b1;
    end
  end

  // Outputs are registered, so they are decoded from the state being entered;
  // the buffer is read at the next index to present restore data in XF_SETUP.
  always_comb begin
    busy_n  = (state_n != ST_IDLE);
    done_n  = 1'b0;
    req_n   = 1'b0;
    oe_n    = 1'b0;
    raddr_n = ADDR_NOP;
    waddr_n = ADDR_NOP;
    ir_n    = idx_n;
    out_n   = '0;
    case (state_n)
      ST_REQ: req_n = 1'b1;
      ST_CTX_SETUP: begin
        req_n = 1'b1;
        oe_n  = 1'b1;
        out_n = ctx_q;
      end
      ST_CTX_STROBE: begin
        req_n   = 1'b1;
        oe_n    = 1'b1;
        out_n   = ctx_q;
        waddr_n = ADDR_CTX;
      end
      ST_XF_SETUP: begin
        req_n = 1'b1;
        oe_n  = !save_q;
        out_n = save_q ? '0 : buf_idata;
      end
      ST_XF_STROBE: begin
        req_n = 1'b1;
        oe_n  = !save_q;
        out_n = ibus_out;
        if (save_q) raddr_n = ADDR_MBN;
        else        waddr_n = ADDR_MBN;
      end
      ST_DONE: done_n = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, transfer index and latched operands.
  always_ff @(posedge clk2 or negedge nrsthold) begin
    if (!nrsthold) begin
      state  <= ST_IDLE;
      idx    <= '0;
      save_q <= 1'b0;
      ctx_q  <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      save_q <= save_n;
      ctx_q  <= ctx_n;
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge clk2 or negedge nrsthold) begin
    if (!nrsthold) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bus_req  <= 1'b0;
      raddr    <= ADDR_NOP;
      waddr    <= ADDR_NOP;
      ir_idx   <= '0;
      ibus_oe  <= 1'b0;
      ibus_out <= '0;
    end else begin
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      bus_req  <= req_n;
      raddr    <= raddr_n;
      waddr    <= waddr_n;
      ir_idx   <= ir_n;
      ibus_oe  <= oe_n;
      ibus_out <= out_n;
    end
  end

endmodule

// File: tb/tb_mbu_ctx_sequencer.sv
// Scoreboard bench for mbu_ctx_sequencer: dut_a has the CTX phase, dut_b skips it.
module tb_mbu_ctx_sequencer;
  import mbu_ctx_sequencer_pkg::*;

  typedef struct {
    logic [4:0] waddr;
    logic [4:0] raddr;
    logic [2:0] ir;
    logic       oe;
    logic [7:0] data;
  } exp_t;

  logic       clk2 = 1'b0;
  logic       nrsthold;
  logic       save;
  logic [7:0] ctx_in;
  logic       buf_we;
  logic [2:0] buf_widx, buf_ridx;
  logic [7:0] buf_wdata;

  logic       start_a, gnt_a, busy_a, done_a, err_a, req_a, oe_a;
  logic [4:0] raddr_a, waddr_a;
  logic [2:0] ir_a;
  logic [7:0] out_a, in_a, rdata_a;

  logic       start_b, gnt_b, busy_b, done_b, err_b, req_b, oe_b;
  logic [4:0] raddr_b, waddr_b;
  logic [2:0] ir_b;
  logic [7:0] out_b, in_b, rdata_b;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  logic [7:0] img [8];

  always #5 clk2 = ~clk2;

  // Behavioural MBU: a read of MBn returns &A0 + index.
  assign in_a = (raddr_a == ADDR_MBN) ? 8'hA0 + {5'b0, ir_a} : 8'h00;
  assign in_b = (raddr_b == ADDR_MBN) ? 8'hA0 + {5'b0, ir_b} : 8'h00;

  mbu_ctx_sequencer #(.delay(15), .CTX_FIRST(1'b1)) dut_a (
    .clk2(clk2), .nrsthold(nrsthold), .start(start_a), .save(save), .ctx_in(ctx_in),
    .busy(busy_a), .done(done_a), .err(err_a), .bus_req(req_a), .bus_gnt(gnt_a),
    .raddr(raddr_a), .waddr(waddr_a), .ir_idx(ir_a), .ibus_oe(oe_a), .ibus_out(out_a),
    .ibus_in(in_a), .buf_we(buf_we), .buf_widx(buf_widx), .buf_wdata(buf_wdata),
    .buf_ridx(buf_ridx), .buf_rdata(rdata_a)
  );

  mbu_ctx_sequencer #(.delay(15), .CTX_FIRST(1'b0)) dut_b (
    .clk2(clk2), .nrsthold(nrsthold), .start(start_b), .save(save), .ctx_in(ctx_in),
    .busy(busy_b), .done(done_b), .err(err_b), .bus_req(req_b), .bus_gnt(gnt_b),
    .raddr(raddr_b), .waddr(waddr_b), .ir_idx(ir_b), .ibus_oe(oe_b), .ibus_out(out_b),
    .ibus_in(in_b), .buf_we(buf_we), .buf_widx(buf_widx), .buf_wdata(buf_wdata),
    .buf_ridx(buf_ridx), .buf_rdata(rdata_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] w, input logic [4:0] r, input logic [2:0] ir,
                              input logic oe, input logic [7:0] d);
    exp_t e;
    e.waddr = w; e.raddr = r; e.ir = ir; e.oe = oe; e.data = d;
    return e;
  endfunction

  // Scoreboard for dut_a: every strobe cycle pops one expected transfer.
  always @(negedge clk2) begin
    if (nrsthold && (waddr_a != ADDR_NOP || raddr_a != ADDR_NOP)) begin
      check("a_bus_clean", 32'((waddr_a != ADDR_NOP && raddr_a != ADDR_NOP) || (oe_a && raddr_a != ADDR_NOP)), 0);
      if (q_a.size() == 0) check("a_unexpected_strobe", 32'({waddr_a, raddr_a}), 0);
      else begin
        ea = q_a.pop_front();
        check("a_waddr", 32'(waddr_a), 32'(ea.waddr));
        check("a_raddr", 32'(raddr_a), 32'(ea.raddr));
        check("a_ir_idx", 32'(ir_a), 32'(ea.ir));
        check("a_ibus_oe", 32'(oe_a), 32'(ea.oe));
        if (ea.oe) check("a_ibus_out", 32'(out_a), 32'(ea.data));
      end
    end
  end

  // Scoreboard for dut_b.
  always @(negedge clk2) begin
    if (nrsthold && (waddr_b != ADDR_NOP || raddr_b != ADDR_NOP)) begin
      check("b_bus_clean", 32'((waddr_b != ADDR_NOP && raddr_b != ADDR_NOP) || (oe_b && raddr_b != ADDR_NOP)), 0);
      if (q_b.size() == 0) check("b_unexpected_strobe", 32'({waddr_b, raddr_b}), 0);
      else begin
        eb = q_b.pop_front();
        check("b_waddr", 32'(waddr_b), 32'(eb.waddr));
        check("b_raddr", 32'(raddr_b), 32'(eb.raddr));
        check("b_ir_idx", 32'(ir_b), 32'(eb.ir));
        check("b_ibus_oe", 32'(oe_b), 32'(eb.oe));
        if (eb.oe) check("b_ibus_out", 32'(out_b), 32'(eb.data));
      end
    end
  end

  task automatic host_fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk2);
      buf_we = 1'b1; buf_widx = 3'(i); buf_wdata = base + 8'(i);
      img[i] = base + 8'(i);
    end
    @(negedge clk2);
    buf_we = 1'b0;
  endtask

  task automatic check_buf_a(input string tag, input int idx, input logic [7:0] exp);
    @(negedge clk2);
    buf_ridx = 3'(idx);
    #1;
    check(tag, 32'(rdata_a), 32'(exp));
  endtask

  task automatic push_a(input logic sv, input logic [7:0] ctx, input int n);
    q_a.push_back(mk(ADDR_CTX, ADDR_NOP, 3'd0, 1'b1, ctx));
    for (int i = 0; i < n; i++)
      q_a.push_back(sv ? mk(ADDR_NOP, ADDR_MBN, 3'(i), 1'b0, 8'h00)
                       : mk(ADDR_MBN, ADDR_NOP, 3'(i), 1'b1, img[i]));
  endtask

  task automatic start_a_op(input logic sv, input logic [7:0] ctx);
    @(negedge clk2);
    save = sv; ctx_in = ctx; start_a = 1'b1;
    @(negedge clk2);
    start_a = 1'b0;
    check("a_req_after_start", 32'({busy_a, req_a}), 32'h3);
  endtask

  task automatic grant_a_after(input int n);
    repeat (n) @(negedge clk2);
    gnt_a = 1'b1;
  endtask

  // Called at the moment grant is raised during a REQ cycle (cycle 1).
  task automatic wait_done(input bit use_b, input int exp_cyc);
    int cyc;
    bit seen;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk2); #1;
      cyc++;
      if ((use_b ? done_b : done_a) == 1'b1) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", 32'(cyc), 32'(exp_cyc));
    check("busy_during_done", 32'(use_b ? busy_b : busy_a), 1);
    @(posedge clk2); #1;
    check("idle_after_done", 32'(use_b ? {busy_b, done_b, req_b} : {busy_a, done_a, req_a}), 0);
    @(negedge clk2);
    gnt_a = 1'b0; gnt_b = 1'b0;
    check("queue_drained", 32'(use_b ? q_b.size() : q_a.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    nrsthold = 1'b0; save = 1'b0; ctx_in = '0;
    buf_we = 1'b0; buf_widx = '0; buf_wdata = '0; buf_ridx = '0;
    start_a = 1'b0; gnt_a = 1'b0; start_b = 1'b0; gnt_b = 1'b0;
    repeat (3) @(negedge clk2);
    check("a_reset_outputs", 32'({busy_a, done_a, err_a, req_a, oe_a, raddr_a, waddr_a, ir_a, out_a}), 0);
    check("b_reset_outputs", 32'({busy_b, done_b, err_b, req_b, oe_b, raddr_b, waddr_b, ir_b, out_b}), 0);
    nrsthold = 1'b1;
    @(negedge clk2);
    check("a_idle_after_reset", 32'({busy_a, req_a, raddr_a, waddr_a}), 0);

    // Restore with CTX phase
    host_fill(8'h10);
    push_a(1'b0, 8'h05, 8);
    start_a_op(1'b0, 8'h05);
    grant_a_after(2);
    wait_done(1'b0, 20);

    // Save: MBU model data lands in the buffer
    push_a(1'b1, 8'h06, 8);
    start_a_op(1'b1, 8'h06);
    grant_a_after(2);
    wait_done(1'b0, 20);
    for (int i = 0; i < 8; i++) check_buf_a("save_buf", i, 8'hA0 + 8'(i));

    // Save aborted by grant loss during XF_STROBE of index 3
    host_fill(8'h30);
    push_a(1'b1, 8'h33, 4);
    start_a_op(1'b1, 8'h33);
    grant_a_after(2);
    k = 0;
    while (!(raddr_a == ADDR_MBN && ir_a == 3'd3) && k < 40) begin
      @(negedge clk2);
      k++;
    end
    check("abort_reached_idx3", 32'(k < 40), 1);
    gnt_a = 1'b0;
    @(posedge clk2); #1;
    check("abort_err", 32'(err_a), 1);
    check("abort_outputs", 32'({busy_a, done_a, req_a, oe_a, raddr_a, waddr_a, ir_a, out_a}), 0);
    @(posedge clk2); #1;
    check("abort_err_pulse", 32'(err_a), 0);
    check("abort_queue", 32'(q_a.size()), 0);
    for (int i = 0; i < 8; i++)
      check_buf_a("abort_buf", i, (i < 4) ? 8'hA0 + 8'(i) : 8'h30 + 8'(i));

    // Async reset in the middle of a restore, then a clean full run
    host_fill(8'h40);
    push_a(1'b0, 8'h44, 6);
    start_a_op(1'b0, 8'h44);
    grant_a_after(2);
    k = 0;
    while (!(waddr_a == ADDR_MBN && ir_a == 3'd5) && k < 40) begin
      @(negedge clk2);
      k++;
    end
    check("reset_reached_idx5", 32'(k < 40), 1);
    #2 nrsthold = 1'b0;
    #1;
    check("async_reset_outputs", 32'({busy_a, done_a, err_a, req_a, oe_a, raddr_a, waddr_a, ir_a, out_a}), 0);
    check("reset_queue", 32'(q_a.size()), 0);
    gnt_a = 1'b0;
    @(negedge clk2);
    nrsthold = 1'b1;
    push_a(1'b0, 8'h45, 8);
    start_a_op(1'b0, 8'h45);
    grant_a_after(2);
    wait_done(1'b0, 20);

    // No CTX phase; a second start while busy is ignored
    host_fill(8'h50);
    for (int i = 0; i < 8; i++) q_b.push_back(mk(ADDR_MBN, ADDR_NOP, 3'(i), 1'b1, img[i]));
    @(negedge clk2);
    save = 1'b0; ctx_in = 8'h55; start_b = 1'b1;
    @(negedge clk2);
    start_b = 1'b0;
    @(negedge clk2);
    start_b = 1'b1;
    @(negedge clk2);
    start_b = 1'b0;
    gnt_b = 1'b1;
    wait_done(1'b1, 18);
    repeat (3) @(negedge clk2);
    check("b_second_start_ignored", 32'({busy_b, req_b}), 0);

    // Host write during busy is dropped
    host_fill(8'h60);
    push_a(1'b0, 8'h66, 8);
    start_a_op(1'b0, 8'h66);
    buf_we = 1'b1; buf_widx = 3'd2; buf_wdata = 8'hFF;
    @(negedge clk2);
    buf_we = 1'b0;
    gnt_a = 1'b1;
    wait_done(1'b0, 20);
    check_buf_a("busy_write_dropped", 2, 8'h62);

    // Host write coincident with start is transferred
    img[4] = 8'hC4;
    push_a(1'b0, 8'h67, 8);
    @(negedge clk2);
    save = 1'b0; ctx_in = 8'h67; start_a = 1'b1;
    buf_we = 1'b1; buf_widx = 3'd4; buf_wdata = 8'hC4;
    @(negedge clk2);
    start_a = 1'b0; buf_we = 1'b0;
    grant_a_after(2);
    wait_done(1'b0, 20);
    check_buf_a("coincident_write", 4, 8'hC4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
